// File: rtl/t3_fifo_pkg.sv
// -----------------------------------------------------------------------------
// t3_fifo_pkg
// Shared constants and types for the t3_fifo show-ahead FIFO.
//   T3_DEPTH / T3_WIDTH : default geometry (entries / data bits per entry)
//   cnt_width()         : width of an occupancy counter able to hold 0..depth
//   T3_CNT_W            : counter width for the default depth
//   fifo_op_e           : per-cycle accepted operation, {push, pop}
// -----------------------------------------------------------------------------
package t3_fifo_pkg;

    localparam int unsigned T3_DEPTH = 32;
    localparam int unsigned T3_WIDTH = 24;

    // The count must represent DEPTH itself, so it needs one bit more
    // than the pointers.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned T3_CNT_W = cnt_width(T3_DEPTH);

    // Encoding is {push_accepted, pop_accepted} so it can be built by a cast.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/t3_fifo_if.sv
// -----------------------------------------------------------------------------
// t3_fifo_if
// Handshake/data bundle of the t3_fifo.
//   write, read, wdata : requester -> FIFO
//   rdata              : head entry, valid whenever empty = 0
//   full, empty, count : registered occupancy status
// Modports: master (requester side), slave (FIFO side).
// DEPTH/WIDTH must match the parameters of the t3_fifo it is connected to.
// -----------------------------------------------------------------------------
interface t3_fifo_if import t3_fifo_pkg::*; #(
    parameter int unsigned DEPTH = T3_DEPTH,
    parameter int unsigned WIDTH = T3_WIDTH
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic             write;
    logic             read;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    modport master (
        output write, read, wdata,
        input  rdata, full, empty, count
    );

    modport slave (
        input  write, read, wdata,
        output rdata, full, empty, count
    );

endinterface

// File: rtl/t3_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// t3_fifo_ctrl
// Pointer and occupancy management for t3_fifo.
//   clk, reset        : clock, asynchronous active-low reset
//   write_i, read_i   : push / pop requests
//   we_o              : storage write enable (push accepted this cycle)
//   waddr_o, raddr_o  : tail and head pointers
//   full_o, empty_o   : occupancy flags, decoded from the registered count
//   count_o           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module t3_fifo_ctrl import t3_fifo_pkg::*; #(
    parameter  int unsigned DEPTH = T3_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write_i,
    input  logic          read_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [AW-1:0] raddr_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic     full_w;
    logic     empty_w;
    logic     pop_ok;
    logic     push_ok;
    fifo_op_e op;

    // Flags come straight from the registered count, so they only move
    // after a clock edge or reset.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A pop frees a slot in the same cycle, which lets a full FIFO accept
    // a push alongside it (delay-line operation). When full, empty is 0,
    // so read alone guarantees the pop.
    assign pop_ok  = read_i && !empty_w;
    assign push_ok = write_i && (!full_w || pop_ok);
    assign op      = fifo_op_e'({push_ok, pop_ok});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign we_o    = push_ok;
    assign waddr_o = wr_ptr_q;
    assign raddr_o = rd_ptr_q;
    assign full_o  = full_w;
    assign empty_o = empty_w;
    assign count_o = count_q;

endmodule

// File: rtl/t3_fifo.sv
// -----------------------------------------------------------------------------
// t3_fifo
// Single-clock show-ahead FIFO, DEPTH entries of WIDTH bits.
//   clk   : clock, all state changes on its rising edge
//   reset : asynchronous active-low reset (clears pointers and count only)
//   bus   : t3_fifo_if slave -- write/read/wdata in, rdata/full/empty/count out
// The head entry is driven combinationally on rdata so a pop consumes the
// value visible in the same cycle. rdata is meaningless while empty = 1.
// -----------------------------------------------------------------------------
module t3_fifo import t3_fifo_pkg::*; #(
    parameter int unsigned DEPTH = T3_DEPTH,
    parameter int unsigned WIDTH = T3_WIDTH
) (
    input logic        clk,
    input logic        reset,
    t3_fifo_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // Storage is deliberately not reset: entries are only reachable
    // through the head pointer after being written, so stale data never
    // surfaces through a valid pop.
    logic [WIDTH-1:0] mem_q [DEPTH];

    t3_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .write_i (bus.write),
        .read_i  (bus.read),
        .we_o    (we),
        .waddr_o (waddr),
        .raddr_o (raddr),
        .full_o  (bus.full),
        .empty_o (bus.empty),
        .count_o (bus.count)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= bus.wdata;
        end
    end

    // Asynchronous read of the head entry gives the show-ahead behaviour;
    // this maps to distributed rather than block RAM.
    assign bus.rdata = mem_q[raddr];

endmodule

// File: tb/tb_t3_fifo.sv
// -----------------------------------------------------------------------------
// tb_t3_fifo
// Directed and random stimulus for t3_fifo (DEPTH=8, WIDTH=24), compared
// against a queue-based reference of the FIFO's behaviour.
// -----------------------------------------------------------------------------
module tb_t3_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    t3_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    t3_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference: the FIFO contents, oldest first.
    logic [WIDTH-1:0] model_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(model_q.size()));
        check({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
        if (model_q.size() > 0)
            check({tag, "_rdata"}, 32'(bus.rdata), 32'(model_q[0]));
    endtask

    // One clock cycle: drive on the falling edge, check the pre-edge view,
    // then apply the same request to the reference after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d,
                         input string tag);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        bus.write = w;
        bus.read  = r;
        bus.wdata = d;
        #1;
        check_state(tag);
        pop_ok  = r && (model_q.size() > 0);
        push_ok = w && ((model_q.size() < DEPTH) || pop_ok);
        @(posedge clk);
        #1;
        if (pop_ok)  void'(model_q.pop_front());
        if (push_ok) model_q.push_back(d);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        $display("cycle %s w=%0d r=%0d d=%0d -> count=%0d", tag, w, r, d, bus.count);
    endtask

    initial begin
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.wdata = '0;

        // Reset
        #2 reset = 1'b0;
        #1;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 1'b1, '0, "pop_empty");
        check("pop_empty_count", 32'(bus.count), 32'd0);

        // Fill 1..8, overflow push ignored, drain in order
        for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, WIDTH'(k), "fill");
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd8);
        cycle(1'b1, 1'b0, WIDTH'(99), "overflow");
        check("ovf_count", 32'(bus.count), 32'd8);
        check("ovf_head",  32'(bus.rdata), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b1, '0, "drain");
            if (k < 8) check("drain_head", 32'(bus.rdata), 32'(k + 1));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Delay-line mode: full with simultaneous push and pop
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, WIDTH'(k), "dl_fill");
        check("dl_full0", 32'(bus.full), 32'd1);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b1, WIDTH'(100 + k), "delay");
            check("dl_full", 32'(bus.full),  32'd1);
            check("dl_head", 32'(bus.rdata), (k + 1 < 8) ? 32'(k + 1) : 32'(100 + k + 1 - 8));
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, '0, "dl_drain");

        // Alternating push/pop across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(1'b1, 1'b0, WIDTH'($urandom), "wrap_push");
            else            cycle(1'b0, 1'b1, '0, "wrap_pop");
            check("wrap_cnt_le1", 32'(bus.count <= 1), 32'd1);
        end

        // Simultaneous push and pop while empty
        cycle(1'b1, 1'b1, WIDTH'(5), "sim_empty");
        check("sim_count", 32'(bus.count), 32'd1);
        check("sim_rdata", 32'(bus.rdata), 32'd5);
        cycle(1'b0, 1'b1, '0, "sim_pop");

        // Reset in the middle of operation
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, WIDTH'($urandom), "pre_rst");
        check("pre_rst_count", 32'(bus.count), 32'd5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_full",  32'(bus.full),  32'd0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, WIDTH'(7), "post_rst_push");
        check("post_rst_rdata", 32'(bus.rdata), 32'd7);
        cycle(1'b0, 1'b1, '0, "post_rst_pop");
        check("post_rst_empty", 32'(bus.empty), 32'd1);

        // Random traffic against the reference
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  WIDTH'($urandom), "rand");
        end
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/t3_fifo.md
T3_FIFO -- requirements
Module: t3_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of entries; power of two and at least 2.
REQ-002 SHALL have parameter WIDTH, default 24, meaning data bits per entry.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port write, input, 1 bit: push request for wdata.
REQ-006 SHALL have port read, input, 1 bit: pop request for the head entry.
REQ-007 SHALL have port wdata, input, WIDTH bits: data to push.
REQ-008 SHALL have port rdata, output, WIDTH bits: current head (oldest) entry.
REQ-009 SHALL have port full, output, 1 bit: high when the FIFO holds DEPTH entries.
REQ-010 SHALL have port empty, output, 1 bit: high when the FIFO holds 0 entries.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries, 0..DEPTH.

Function
REQ-012 SHALL present the head entry on rdata combinationally (show-ahead), so the value consumed by a pop is valid in the same cycle read is asserted.
REQ-013 SHALL accept a push when write=1 and (full=0 or read=1 with a pop accepted that cycle); wdata is stored at the tail.
REQ-014 SHALL accept a pop when read=1 and empty=0; the head advances one entry at the clock edge.
REQ-015 SHALL ignore a push while full with no accepted pop; contents, pointers and count remain unchanged.
REQ-016 SHALL ignore a pop while empty; a simultaneous push while empty SHALL still be accepted.
REQ-017 SHALL, when full and read=write=1, pop the head and push wdata in the same cycle, with count staying at DEPTH and full staying 1 (fixed-length delay-line mode).
REQ-018 SHALL, when neither full nor empty and read=write=1, perform both operations with count unchanged.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH.
REQ-020 SHALL derive full, empty and count from registered state only, so they change only after a clock edge or reset.
REQ-021 SHALL leave rdata content undefined (don't-care) while empty=1.
REQ-022 SHALL pass data unmodified, with no sign or width conversion.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear both pointers and count to 0, set empty=1 and full=0.
REQ-024 SHALL NOT reset the storage array; stale entries are never observable through a valid pop.
REQ-025 SHALL discard all stored entries when reset is asserted mid-operation; the first push after release lands at entry 0.

Structure
REQ-026 SHALL take DEPTH and WIDTH default constants from shared package t3_fifo_pkg, which also holds a count-width helper constant.
REQ-027 SHALL place pointer and count management in a sub-module t3_fifo_ctrl that outputs the write enable, pointers, full, empty and count; t3_fifo holds the storage array.

Verification (DEPTH=8, WIDTH=24)
REQ-028 SHALL verify reset: after reset=0 then 1, empty=1, full=0 and count=0; read=1 on an empty FIFO leaves count=0.
REQ-029 SHALL verify fill and drain: push 1..8, then full=1 and count=8; a 9th push of 99 is ignored; popping 8 times returns 1..8 in order on rdata, and empty=1 at the end.
REQ-030 SHALL verify delay-line mode: fill with 0..7, then hold read=write=1 with wdata=100+k; rdata shows 0,1,2,... and full remains 1 throughout.
REQ-031 SHALL verify wrap-around: run 20 alternating push/pop cycles crossing the pointer wrap; data order is preserved and count stays within 0..1.
REQ-032 SHALL verify simultaneous push and pop on an empty FIFO: the push of 5 is accepted, count=1 and rdata=5 in the next cycle.
REQ-033 SHALL verify mid-operation reset: with count=5, a reset pulse gives count=0 and empty=1; a subsequent push of 7 then pop returns 7.
